// File: rtl/i2c_slave.sv
// I2C register-bus responder: oversampled START/STOP/bit decode, address match, pointer + burst write/read.
// Optional 3-sample line filter when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic       wr_en,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_REG, ST_ACK_R,
    ST_WDATA, ST_ACK_W, ST_RDATA, ST_MACK, ST_IGNORE
  } state_t;

  // Stage p0/p1: two-flop synchronizers (idle bus level is high)
  logic scl_p0, scl_p1, sda_p0, sda_p1;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= scl_in;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_in;
      sda_p1 <= sda_p0;
    end
  end

  logic scl_f, sda_f;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  // Filter stage: level follows only after three equal consecutive samples
  logic [1:0] scl_h, sda_h;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_p1};
      sda_h <= {sda_h[0], sda_p1};
      if (scl_p1 == scl_h[0] && scl_p1 == scl_h[1]) scl_f <= scl_p1;
      if (sda_p1 == sda_h[0] && sda_p1 == sda_h[1]) sda_f <= sda_p1;
    end
  end
`else
  assign scl_f = scl_p1;
  assign sda_f = sda_p1;
`endif

  // Stage p2: edge and bus-condition strobes; START/STOP use the new SCL level
  logic scl_p2, sda_p2, rise_p2, fall_p2, start_p2, stop_p2;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p2   <= 1'b1;
      sda_p2   <= 1'b1;
      rise_p2  <= 1'b0;
      fall_p2  <= 1'b0;
      start_p2 <= 1'b0;
      stop_p2  <= 1'b0;
    end else begin
      scl_p2   <= scl_f;
      sda_p2   <= sda_f;
      rise_p2  <= scl_f & ~scl_p2;
      fall_p2  <= ~scl_f & scl_p2;
      start_p2 <= ~sda_f & sda_p2 & scl_f;
      stop_p2  <= sda_f & ~sda_p2 & scl_f;
    end
  end

  state_t     state, state_n;
  logic [3:0] bit_cnt, cnt_n;
  logic [7:0] sr, sr_n, addr_n, wr_data_n;
  logic       rw, rw_n, nack, nack_n, oe_n, wr_en_n, busy_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= 4'd0;
      sr       <= 8'd0;
      rw       <= 1'b0;
      nack     <= 1'b0;
      sda_oe   <= 1'b0;
      reg_addr <= 8'd0;
      wr_en    <= 1'b0;
      wr_data  <= 8'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= cnt_n;
      sr       <= sr_n;
      rw       <= rw_n;
      nack     <= nack_n;
      sda_oe   <= oe_n;
      reg_addr <= addr_n;
      wr_en    <= wr_en_n;
      wr_data  <= wr_data_n;
      busy     <= busy_n;
    end
  end

  logic [7:0] byte_in;
  logic       rx_state, last_bit, byte_end;
  assign byte_in  = {sr[6:0], sda_p2};
  assign rx_state = (state == ST_ADDR) || (state == ST_REG) || (state == ST_WDATA);
  assign last_bit = rise_p2 && (bit_cnt == 4'd7);
  assign byte_end = fall_p2 && (bit_cnt == 4'd8);

  always_comb begin
    state_n   = state;
    cnt_n     = bit_cnt;
    sr_n      = sr;
    rw_n      = rw;
    nack_n    = nack;
    oe_n      = sda_oe;
    addr_n    = reg_addr;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data;
    busy_n    = busy;
    if (stop_p2) begin
      state_n = ST_IDLE;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (start_p2) begin
      state_n = ST_ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      // Receive states hold bit_cnt at 8 between the last data bit and the ACK clock
      if (rx_state && rise_p2 && bit_cnt < 4'd8) begin
        sr_n  = byte_in;
        cnt_n = bit_cnt + 4'd1;
      end
      case (state)
        ST_ADDR: begin
          if (last_bit) begin
            if (sr[6:0] == ADDR) begin
              rw_n   = sda_p2;
              busy_n = 1'b1;
            end else begin
              state_n = ST_IGNORE;
            end
          end else if (byte_end) begin
            state_n = ST_ACK_A;
            cnt_n   = 4'd0;
            oe_n    = 1'b1;
          end
        end
        ST_ACK_A: begin
          if (fall_p2) begin
            cnt_n = 4'd0;
            if (rw) begin
              state_n = ST_RDATA;
              sr_n    = rd_data;
              oe_n    = ~rd_data[7];
            end else begin
              state_n = ST_REG;
              oe_n    = 1'b0;
            end
          end
        end
        ST_REG: begin
          if (last_bit) begin
            addr_n = byte_in;
          end else if (byte_end) begin
            state_n = ST_ACK_R;
            cnt_n   = 4'd0;
            oe_n    = 1'b1;
          end
        end
        ST_ACK_R: begin
          if (fall_p2) begin
            state_n = ST_WDATA;
            oe_n    = 1'b0;
          end
        end
        ST_WDATA: begin
          if (byte_end) begin
            state_n   = ST_ACK_W;
            cnt_n     = 4'd0;
            oe_n      = 1'b1;
            wr_en_n   = 1'b1;
            wr_data_n = sr;
          end
        end
        ST_ACK_W: begin
          if (fall_p2) begin
            state_n = ST_WDATA;
            oe_n    = 1'b0;
            addr_n  = reg_addr + 8'd1;
          end
        end
        ST_RDATA: begin
          if (rise_p2 && bit_cnt < 4'd8) begin
            cnt_n = bit_cnt + 4'd1;
          end else if (byte_end) begin
            state_n = ST_MACK;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
          end else if (fall_p2 && bit_cnt != 4'd0) begin
            sr_n = {sr[6:0], 1'b0};
            oe_n = ~sr[6];
          end
        end
        ST_MACK: begin
          // Pointer advances at the ACK sample so rd_data is settled by the next fall
          if (rise_p2) begin
            nack_n = sda_p2;
            if (!sda_p2) addr_n = reg_addr + 8'd1;
          end else if (fall_p2) begin
            if (nack) begin
              state_n = ST_IGNORE;
              oe_n    = 1'b0;
            end else begin
              state_n = ST_RDATA;
              cnt_n   = 4'd0;
              sr_n    = rd_data;
              oe_n    = ~rd_data[7];
            end
          end
        end
        default: oe_n = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged I2C master, pointer^0xFF register file, write-strobe log.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int TQ = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sdam = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_en, busy;
  logic [7:0] reg_addr, wr_data, rd_data;

  int n_total = 0;
  int n_bad = 0;
  int oe_cnt = 0;
  logic [15:0] wq[$];

  always #5 clk = ~clk;

  assign sda_line = sdam & ~sda_oe;
  assign rd_data  = reg_addr ^ 8'hFF;

  i2c_slave dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_en) wq.push_back({reg_addr, wr_data});
    if (sda_oe) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input int idx, input logic [15:0] exp);
    logic [15:0] got;
    got = (idx < wq.size()) ? wq[idx] : 16'hDEAD;
    chk($sformatf("wr%0d", idx), {16'd0, got}, {16'd0, exp});
  endtask

  task automatic quarter();
    repeat (TQ) @(negedge clk);
  endtask

  task automatic bus_start();
    sdam = 1'b1; quarter();
    scl  = 1'b1; quarter();
    sdam = 1'b0; quarter();
    scl  = 1'b0; quarter();
  endtask

  task automatic bus_stop();
    sdam = 1'b0; quarter();
    scl  = 1'b1; quarter();
    sdam = 1'b1; quarter();
    quarter();
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sdam = b; quarter();
    scl  = 1'b1; quarter();
    s    = sda_line; quarter();
    scl  = 1'b0; quarter();
  endtask

  task automatic tx_byte(input logic [7:0] b, input logic exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    chk($sformatf("ack_%02h", b), {31'd0, s}, {31'd0, exp_ack});
  endtask

  task automatic rx_byte(input logic ack, output logic [7:0] d);
    logic s;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, s);
      d = {d[6:0], s};
    end
    bit_xfer(ack, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       s;
    bit         seen;

    repeat (4) @(negedge clk);
    chk("rst_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    quarter();

    // burst write at 0x10
    wq.delete();
    bus_start();
    tx_byte(8'h84, 1'b0);
    chk("wr_busy_mid", {31'd0, busy}, 32'd1);
    tx_byte(8'h10, 1'b0);
    tx_byte(8'hA5, 1'b0);
    tx_byte(8'h5A, 1'b0);
    bus_stop();
    chk("wr_count", wq.size(), 32'd2);
    chk_wr(0, 16'h10A5);
    chk_wr(1, 16'h115A);
    chk("wr_ptr", {24'd0, reg_addr}, 32'h12);
    chk("wr_busy_end", {31'd0, busy}, 32'd0);

    // read two bytes from 0x20
    wq.delete();
    bus_start();
    tx_byte(8'h84, 1'b0);
    tx_byte(8'h20, 1'b0);
    bus_stop();
    bus_start();
    tx_byte(8'h85, 1'b0);
    rx_byte(1'b0, d);
    chk("rd_byte0", {24'd0, d}, 32'hDF);
    rx_byte(1'b1, d);
    chk("rd_byte1", {24'd0, d}, 32'hDE);
    bus_stop();
    chk("rd_ptr", {24'd0, reg_addr}, 32'h21);
    chk("rd_no_wr", wq.size(), 32'd0);

    // address mismatch
    oe_cnt = 0;
    bus_start();
    tx_byte(8'h86, 1'b1);
    chk("mm_busy", {31'd0, busy}, 32'd0);
    tx_byte(8'h55, 1'b1);
    bus_stop();
    chk("mm_oe_cycles", oe_cnt, 32'd0);
    chk("mm_no_wr", wq.size(), 32'd0);
    chk("mm_ptr", {24'd0, reg_addr}, 32'h21);

    // repeated START into a read
    bus_start();
    tx_byte(8'h84, 1'b0);
    tx_byte(8'h30, 1'b0);
    bus_start();
    tx_byte(8'h85, 1'b0);
    chk("rs_busy", {31'd0, busy}, 32'd1);
    rx_byte(1'b1, d);
    chk("rs_byte", {24'd0, d}, 32'hCF);
    bus_stop();
    chk("rs_ptr", {24'd0, reg_addr}, 32'h30);

    // pointer wrap and aborted third byte
    wq.delete();
    bus_start();
    tx_byte(8'h84, 1'b0);
    tx_byte(8'hFF, 1'b0);
    tx_byte(8'h11, 1'b0);
    tx_byte(8'h22, 1'b0);
    for (int i = 0; i < 4; i++) bit_xfer((i >= 2), s);
    bus_stop();
    chk("wrap_count", wq.size(), 32'd2);
    chk_wr(0, 16'hFF11);
    chk_wr(1, 16'h0022);
    chk("wrap_ptr", {24'd0, reg_addr}, 32'h01);

    // reset while the slave is pulling SDA low during a read of 0x80 (data 0x7F)
    bus_start();
    tx_byte(8'h84, 1'b0);
    tx_byte(8'h80, 1'b0);
    bus_stop();
    bus_start();
    tx_byte(8'h85, 1'b0);
    sdam = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (sda_oe) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rr_oe_before", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_oe", {31'd0, sda_oe}, 32'd0);
    chk("rr_ptr", {24'd0, reg_addr}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scl = 1'b1;
    quarter();
    quarter();

    // normal write after reset
    wq.delete();
    bus_start();
    tx_byte(8'h84, 1'b0);
    tx_byte(8'h05, 1'b0);
    tx_byte(8'h77, 1'b0);
    bus_stop();
    chk("pr_count", wq.size(), 32'd1);
    chk_wr(0, 16'h0577);
    chk("pr_ptr", {24'd0, reg_addr}, 32'h06);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // a 2-clk SDA low pulse with SCL high must not open a transaction
    wq.delete();
    @(negedge clk);
    sdam = 1'b0;
    repeat (2) @(negedge clk);
    sdam = 1'b1;
    quarter();
    quarter();
    scl = 1'b0;
    quarter();
    tx_byte(8'h84, 1'b1);
    chk("gl_busy", {31'd0, busy}, 32'd0);
    bus_stop();
    chk("gl_no_wr", wq.size(), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Byte-oriented I2C responder for the master in the same design. It oversamples SCL/SDA on the system clock and decodes START, STOP and repeated START. It matches a 7-bit device address, takes a register-pointer byte, then either writes data bytes to an external register bus or reads bytes back to the master, auto-incrementing the pointer. It drives SDA open-drain only: the block asserts a pull-low enable and never drives SDA high.

## Interface
- ADDR, 7'h42, 7-bit device address this block answers to
- clk  input  1  system clock; must run at ≥ 16× SCL frequency
- rst  input  1  synchronous, active-high reset
- scl_in  input  1  raw SCL line level (asynchronous)
- sda_in  input  1  raw SDA line level (asynchronous)
- sda_oe  output  1  1 = pull SDA low; 0 = release
- reg_addr  output  8  current register pointer
- wr_en  output  1  one-cycle write strobe
- wr_data  output  8  write data, valid when wr_en=1
- rd_data  input  8  register contents at reg_addr; sampled combinationally from the external file
- busy  output  1  1 from an address-matched START until STOP or the next START

## Operation
- Input path: 2-flop synchronizer per line, then an edge detector on the synchronized values.
- START = SDA falls while SCL is high. STOP = SDA rises while SCL is high. Both are valid in any state. START, including repeated START, always moves to ADDR with the bit count cleared. STOP always moves to IDLE and releases SDA.
- Bits are sampled on the synchronized SCL rising edge, MSB first. Driven bits change on the synchronized SCL falling edge.
- States and transitions:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits {addr[6:0], rw}.
    - On match → ACK_A.
    - On mismatch → IGNORE, with sda_oe=0 until STOP or START.
  - ACK_A: pull SDA low for the 9th clock.
    - rw=0 → REG.
    - rw=1 → RDATA, loading the shift register from rd_data at the falling edge that ends ACK.
  - REG: 8 bits load reg_addr, then ACK_R → WDATA.
  - WDATA: after 8 bits, wr_data = byte and wr_en pulses for exactly one clk at the start of ACK_W. reg_addr then increments on the falling edge that ends ACK_W. Next state WDATA.
  - RDATA: drive bits (sda_oe = ~bit), then MACK, where SDA is released and the 9th bit is sampled.
    - Master ACK (0): increment reg_addr, reload from rd_data on the falling edge, → RDATA.
    - Master NACK (1): → IGNORE.
- reg_addr wraps 8'hFF → 8'h00.
- The pointer persists across transactions, so a read without a preceding REG byte starts at the last pointer.
- A STOP or START arriving mid-byte abandons the partial byte. No wr_en is issued for it.

## Timing
- Reset values: sda_oe=0, wr_en=0, wr_data=0, reg_addr=0, busy=0, state=IDLE, bit count=0.
- Reset overrides any bus activity, including while sda_oe=1.
- Event latency is 3 clk from a line transition to the internal edge/START/STOP strobe. It is 6 clk when the filter is compiled in.
- sda_oe changes 1 clk after the internal SCL-fall strobe. This keeps SDA hold time ≥ 1 clk after SCL low.
- busy rises 1 clk after the 8th ADDR bit matches. It falls 1 clk after the STOP/START strobe.
- SCL/SDA rising together with SCL high is resolved in this order: SCL edge first, then START/STOP.
- No clock stretching: SCL is never driven.

## Configuration
- I2C_SLAVE_GLITCH_FILTER_EN
  - Defined: each synchronized line passes through a 3-sample stability filter, and the output changes only after 3 equal consecutive samples. This adds 3 clk latency and rejects pulses of 2 clk or less.
  - Undefined: synchronizer only, and any 1-clk level is treated as a real transition.

## Test plan
- Write: START, 0x84 (addr 0x42, W), 0x10, 0xA5, 0x5A, STOP → ACK on every byte. wr_en pulses at reg_addr=0x10 with data 0xA5 and at 0x11 with 0x5A. Final reg_addr=0x12 and busy=0.
- Read: pointer=0x20, file returns addr^0xFF. START, 0x85, master ACKs byte 1 and NACKs byte 2, STOP → SDA carries 0xDF then 0xDE, and reg_addr=0x21 afterwards.
- Mismatch: START, 0x86 (addr 0x43) → SDA released for the whole transfer, no wr_en, busy=0.
- Repeated START: write pointer 0x30, then START, 0x85 without STOP → first read byte comes from reg 0x30.
- Wrap and abort: write at pointer 0xFF with bytes 0x11, 0x22 → writes go to 0xFF then 0x00. A STOP after 4 bits of a third byte → no third wr_en.
- Reset mid-read while sda_oe=1 → sda_oe=0 next clk, state IDLE, reg_addr=0. With the macro defined, a 2-clk SDA glitch during SCL high produces no START/STOP.
